// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of bram_port_arbiter: two request lanes packed side by
// side (requester i occupies slice i of each vector) plus the shared read
// response. master = requesters, slave = arbiter.
interface bram_port_arbiter_if #(
  parameter int NB_COL    = 64,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 64
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int DW = NB_COL * COL_WIDTH;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*AW-1:0]     req_addr;
  logic [2*DW-1:0]     req_wdata;
  logic [2*NB_COL-1:0] req_wstrb;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares a 1W/1R byte-write block RAM between two requesters. After reset
// the RAM is zero-filled (CLEAR), then each cycle at most one write is granted
// to port A and one read to port B. Read data returns one cycle after grant.
// Build option: define BRAM_ARB_FIXED_PRIO_EN to make requester 0 always win
// contention (no round-robin state); default build is round-robin per class.
module bram_port_arbiter #(
  parameter int NB_COL    = 64,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 64,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int DW = NB_COL * COL_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  bram_port_arbiter_if.slave  bus,
  output logic                init_done,
  output logic [AW-1:0]       bram_addra,
  output logic [DW-1:0]       bram_dina,
  output logic [NB_COL-1:0]   bram_wea,
  output logic [AW-1:0]       bram_addrb,
  input  logic [DW-1:0]       bram_doutb
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] addrb_q;
  logic [1:0]    rsp_valid_q;
`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic          wr_rr;
  logic          rd_rr;
`endif

  logic       run;
  logic [1:0] wr_cand, rd_cand;
  logic [1:0] wr_gnt, rd_gnt;
  logic       wr_sel, rd_sel;

  // Per-class candidate selection and grants; nothing is granted while in reset.
  always_comb begin
    run     = (state == RUN) && !rst;
    wr_cand = bus.req_valid & bus.req_we;
    rd_cand = bus.req_valid & ~bus.req_we;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    wr_sel  = ~wr_cand[0];
    rd_sel  = ~rd_cand[0];
`else
    wr_sel  = (&wr_cand) ? wr_rr : wr_cand[1];
    rd_sel  = (&rd_cand) ? rd_rr : rd_cand[1];
`endif
    wr_gnt  = '0;
    rd_gnt  = '0;
    if (run && |wr_cand) wr_gnt[wr_sel] = 1'b1;
    if (run && |rd_cand) rd_gnt[rd_sel] = 1'b1;
  end

  // RAM port steering: clear sweep on port A in CLEAR, granted winners in RUN.
  always_comb begin
    if (state == CLEAR) begin
      bram_addra = clr_ptr;
      bram_dina  = '0;
      bram_wea   = rst ? '0 : '1;
    end else begin
      bram_addra = wr_sel ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
      bram_dina  = wr_sel ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
      bram_wea   = '0;
      if (|wr_gnt)
        bram_wea = wr_sel ? bus.req_wstrb[2*NB_COL-1:NB_COL] : bus.req_wstrb[NB_COL-1:0];
    end
    bram_addrb = addrb_q;
    if (|rd_gnt)
      bram_addrb = rd_sel ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
  end

  assign bus.req_ready = wr_gnt | rd_gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = bram_doutb;

  // Sequencer: CLEAR sweep, then RUN with round-robin pointers and response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      addrb_q     <= '0;
      rsp_valid_q <= '0;
      init_done   <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      wr_rr       <= 1'b0;
      rd_rr       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= rd_gnt;
      addrb_q     <= bram_addrb;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == AW'(RAM_DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
`ifndef BRAM_ARB_FIXED_PRIO_EN
          if (&wr_cand) wr_rr <= ~wr_sel;
          if (&rd_cand) rd_rr <= ~rd_sel;
`endif
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a byte-write RAM with registered read address
// (write-first by construction), a request-level reference model, a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_bram_port_arbiter;
  localparam int NB_COL    = 64;
  localparam int COL_WIDTH = 8;
  localparam int RAM_DEPTH = 64;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int DW = NB_COL * COL_WIDTH;
`ifdef BRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              init_done;
  logic [AW-1:0]     bram_addra, bram_addrb;
  logic [DW-1:0]     bram_dina, bram_doutb;
  logic [NB_COL-1:0] bram_wea;

  int checks   = 0;
  int failures = 0;

  bram_port_arbiter_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus ();

  bram_port_arbiter #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(RAM_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .init_done  (init_done),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_wea   (bram_wea),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: byte-lane writes on port A, registered read address on port B.
  logic [DW-1:0] ram [RAM_DEPTH];
  logic [AW-1:0] ram_addrb_q;
  always @(posedge clk) begin
    for (int b = 0; b < NB_COL; b++)
      if (bram_wea[b]) ram[bram_addra][b*COL_WIDTH +: COL_WIDTH] <= bram_dina[b*COL_WIDTH +: COL_WIDTH];
    ram_addrb_q <= bram_addrb;
  end
  assign bram_doutb = ram[ram_addrb_q];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [RAM_DEPTH];
  int            m_clr   = 0;     // clear cycles completed since reset
  int            wr_cont = 0;     // write contentions seen in RUN
  int            rd_cont = 0;     // read contentions seen in RUN
  logic [1:0]    m_rspv  = '0;
  logic [DW-1:0] m_rspd  = '0;

  function automatic logic m_run();
    return m_clr == RAM_DEPTH;
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] c, input int cont);
    if (c == 2'b11) return (FIXED || (cont % 2 == 0)) ? 2'b01 : 2'b10;
    return c;
  endfunction

  function automatic void exp_grants(output logic [1:0] wg, output logic [1:0] rg);
    wg = '0;
    rg = '0;
    if (rst || !m_run()) return;
    wg = pick(bus.req_valid & bus.req_we, wr_cont);
    rg = pick(bus.req_valid & ~bus.req_we, rd_cont);
  endfunction

  always @(posedge clk) begin
    logic [1:0] wg, rg;
    int wi, ri;
    exp_grants(wg, rg);
    if (rst) begin
      m_clr = 0; wr_cont = 0; rd_cont = 0; m_rspv = '0;
      for (int a = 0; a < RAM_DEPTH; a++) ref_mem[a] = '0;
    end else if (!m_run()) begin
      m_clr++;
      m_rspv = '0;
    end else begin
      wi = int'(wg[1]);
      ri = int'(rg[1]);
      if (wg != 0)
        for (int b = 0; b < NB_COL; b++)
          if (bus.req_wstrb[wi*NB_COL + b])
            ref_mem[bus.req_addr[wi*AW +: AW]][b*COL_WIDTH +: COL_WIDTH] =
              bus.req_wdata[wi*DW + b*COL_WIDTH +: COL_WIDTH];
      m_rspv = rg;
      if (rg != 0) m_rspd = ref_mem[bus.req_addr[ri*AW +: AW]];
      if ((bus.req_valid & bus.req_we) == 2'b11) wr_cont++;
      if ((bus.req_valid & ~bus.req_we) == 2'b11) rd_cont++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] wg, rg;
    int wi, ri;
    exp_grants(wg, rg);
    chk("req_ready", DW'(bus.req_ready), DW'(wg | rg));
    chk("rsp_valid", DW'(bus.rsp_valid), DW'(m_rspv));
    if (m_rspv != 0) chk("rsp_data", bus.rsp_data, m_rspd);
    if (!rst) begin
      chk("init_done", DW'(init_done), DW'(m_run()));
      if (!m_run()) begin
        chk("clr_wea", DW'(bram_wea), {{(DW-NB_COL){1'b0}}, {NB_COL{1'b1}}});
        chk("clr_addra", DW'(bram_addra), DW'(m_clr));
        chk("clr_dina", bram_dina, '0);
      end else begin
        wi = int'(wg[1]);
        ri = int'(rg[1]);
        if (wg != 0) begin
          chk("wr_addra", DW'(bram_addra), DW'(bus.req_addr[wi*AW +: AW]));
          chk("wr_dina", bram_dina, bus.req_wdata[wi*DW +: DW]);
          chk("wr_wea", DW'(bram_wea), DW'(bus.req_wstrb[wi*NB_COL +: NB_COL]));
        end else begin
          chk("idle_wea", DW'(bram_wea), '0);
        end
        if (rg != 0) chk("rd_addrb", DW'(bram_addrb), DW'(bus.req_addr[ri*AW +: AW]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [NB_COL-1:0] ws);
    bus.req_valid[i]               = 1'b1;
    bus.req_we[i]                  = we;
    bus.req_addr[i*AW +: AW]       = a;
    bus.req_wdata[i*DW +: DW]      = wd;
    bus.req_wstrb[i*NB_COL +: NB_COL] = ws;
  endtask

  // Counts cycles with init_done low (bounded); returns at the negedge of the first RUN cycle.
  task automatic wait_init(output int n, output int clr_cycles);
    n = 0;
    clr_cycles = 0;
    while (n < 100) begin
      @(negedge clk);
      if (init_done) break;
      if (bram_wea == '1 && bus.req_ready == 2'b00) clr_cycles++;
      n++;
      step();
    end
    step();
  endtask

  task automatic do_read(input int r, input logic [AW-1:0] a,
                         output logic [DW-1:0] d, output logic [1:0] v);
    idle();
    set_req(r, 1'b0, a, '0, '0);
    step();
    idle();
    @(negedge clk);
    v = bus.rsp_valid;
    d = bus.rsp_data;
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int            n, clr;
    logic [DW-1:0] d, all_aa, v11, v22, wd5a, exp4;
    logic [1:0]    v;
    logic [1:0]    seq [4];
    logic [1:0]    rv  [4];

    all_aa = {NB_COL{8'hAA}};
    v11    = {NB_COL{8'h11}};
    v22    = {NB_COL{8'h22}};
    wd5a   = {NB_COL{8'h5A}};
    exp4   = '0;
    exp4[7:0] = 8'h5A;

    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;

    // 1: clear sweep of 64 cycles, init_done on cycle 65, entry 63 reads zero
    wait_init(n, clr);
    chk("t1_clear_cycles", DW'(n), DW'(64));
    chk("t1_wea_cycles", DW'(clr), DW'(64));
    do_read(0, 63, d, v);
    chk("t1_rb63_valid", DW'(v), DW'(2'b01));
    chk("t1_rb63_data", d, '0);

    // 2: write then read from the other requester
    idle();
    set_req(0, 1'b1, 5, all_aa, '1);
    step();
    do_read(1, 5, d, v);
    chk("t2_valid", DW'(v), DW'(2'b10));
    chk("t2_data", d, all_aa);

    // 3: write contention alternates starting with requester 0
    for (int k = 0; k < 4; k++) begin
      idle();
      set_req(0, 1'b1, 1, v11, '1);
      set_req(1, 1'b1, 2, v22, '1);
      @(negedge clk);
      seq[k] = bus.req_ready;
      step();
    end
    idle();
    chk("t3_g0", DW'(seq[0]), DW'(2'b01));
    chk("t3_g1", DW'(seq[1]), DW'(FIXED ? 2'b01 : 2'b10));
    chk("t3_g2", DW'(seq[2]), DW'(2'b01));
    chk("t3_g3", DW'(seq[3]), DW'(FIXED ? 2'b01 : 2'b10));

    // 4: same-cycle partial write and read of addr 7 returns write-first bytes
    idle();
    set_req(0, 1'b1, 7, wd5a, NB_COL'(1));
    set_req(1, 1'b0, 7, '0, '0);
    @(negedge clk);
    chk("t4_ready", DW'(bus.req_ready), DW'(2'b11));
    step();
    idle();
    @(negedge clk);
    chk("t4_valid", DW'(bus.rsp_valid), DW'(2'b10));
    chk("t4_data", bus.rsp_data, exp4);
    step();

    // 5: read contention, one grant per cycle, responses lag by one
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 4) begin
        set_req(0, 1'b0, 3, '0, '0);
        set_req(1, 1'b0, 4, '0, '0);
      end
      @(negedge clk);
      if (k < 4) seq[k] = bus.req_ready;
      if (k > 0) rv[k-1] = bus.rsp_valid;
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_grant%0d", k), DW'(seq[k]), DW'((FIXED || k % 2 == 0) ? 2'b01 : 2'b10));
      chk($sformatf("t5_rsp%0d", k), DW'(rv[k]), DW'((FIXED || k % 2 == 0) ? 2'b01 : 2'b10));
    end

    // 6: reset right after a read grant drops the response and re-clears the RAM
    idle();
    set_req(1, 1'b0, 5, '0, '0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp_dropped", DW'(bus.rsp_valid), '0);
    chk("t6_init_low", DW'(init_done), '0);
    step();
    wait_init(n, clr);
    chk("t6_clear_cycles", DW'(n), DW'(63));
    do_read(1, 5, d, v);
    chk("t6_rb5_valid", DW'(v), DW'(2'b10));
    chk("t6_rb5_data", d, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
